// File: rtl/float_pack.sv
// Shared floating-point format, constants and helpers for the coprocessor datapath.
// float_mul is a single-expression golden reference that uses the same saturation rules as the sequential unit.
package float_pack;

    localparam int N_mantisse = 23;
    localparam int N_exposant = 8;
    localparam int BIAS       = 2**(N_exposant-1) - 1;
    localparam int EXP_MAX    = 2**N_exposant - 2;

    typedef struct packed {
        logic                  s;
        logic [N_exposant-1:0] e;
        logic [N_mantisse-1:0] m;
    } float;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} mul_state_t;

    function automatic float float_zero(input logic sign);
        float z;
        z.s = sign;
        z.e = {N_exposant{1'b0}};
        z.m = {N_mantisse{1'b0}};
        return z;
    endfunction

    function automatic float float_mul(input float a, input float b);
        float                      r;
        logic [2*N_mantisse+1:0]   p;
        int                        e;
        r.s = a.s ^ b.s;
        p = (2*N_mantisse+2)'({1'b1, a.m}) * (2*N_mantisse+2)'({1'b1, b.m});
        e = int'(a.e) + int'(b.e) - BIAS;
        if (p[2*N_mantisse+1]) begin
            r.m = p[2*N_mantisse:N_mantisse+1];
            e   = e + 1;
        end else begin
            r.m = p[2*N_mantisse-1:N_mantisse];
        end
        if ((a.e == {N_exposant{1'b0}}) || (b.e == {N_exposant{1'b0}})) begin
            r = float_zero(r.s);
        end else if (e >= 2**N_exposant - 1) begin
            r.e = N_exposant'(EXP_MAX);
            r.m = {N_mantisse{1'b1}};
        end else if (e <= 0) begin
            r = float_zero(r.s);
        end else begin
            r.e = N_exposant'(e);
        end
        return r;
    endfunction

endpackage

// File: rtl/float_mul_seq_mant_mul_iter.sv
// Iterative shift-add mantissa multiplier: one multiplier bit per cycle, N_M+1 cycles,
// exposes only the upper N_M+2 product bits needed for normalisation.
module mant_mul_iter #(
    parameter int N_M = 23
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N_M:0]   a,
    input  logic [N_M:0]   b,
    output logic           busy,
    output logic           done,
    output logic [N_M+1:0] prod_hi
);

    localparam int CW = $clog2(N_M + 2);

    logic [2*N_M+1:0] mcand_r;
    logic [2*N_M+1:0] acc_r;
    logic [N_M:0]     mplier_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;

    // Shift-add iteration; done pulses for one cycle after the last partial product
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r  <= '0;
            acc_r    <= '0;
            mplier_r <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= {{(N_M+1){1'b0}}, a};
            acc_r    <= '0;
            mplier_r <= b;
            cnt_r    <= '0;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
        end else if (busy_r) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + (mcand_r << cnt_r);
            end
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CW'(1);
            if (cnt_r == CW'(N_M)) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign prod_hi = acc_r[2*N_M+1:N_M];

endmodule

// File: rtl/float_mul_seq.sv
// Sequential float multiplier: latches operands, runs the iterative mantissa multiplier,
// then normalises, saturates/flushes and holds the result under a valid/ready handshake.
module float_mul_seq
    import float_pack::*;
#(
    parameter int N_M = float_pack::N_mantisse,
    parameter int N_E = float_pack::N_exposant
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_E+N_M:0] op1,
    input  logic [N_E+N_M:0] op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_E+N_M:0] result,
    output logic             ovf,
    output logic             unf
);

    localparam int EW     = N_E + 2;
    localparam int E_BIAS = 2**(N_E-1) - 1;
    localparam logic signed [EW-1:0] E_SAT_S  = EW'(2**N_E - 1);
    localparam logic signed [EW-1:0] E_ZERO_S = EW'(0);
    localparam logic [N_E-1:0]       E_MAXV   = N_E'(2**N_E - 2);

    mul_state_t             state_r, state_n;
    logic                   in_ready_r, out_valid_r;
    logic [N_E+N_M:0]       result_r;
    logic                   ovf_r, unf_r;
    logic                   sign_r, zero_r;
    logic signed [EW-1:0]   exp_r;

    logic                   accept_s;
    logic                   mul_busy_s, mul_done_s;
    logic [N_M+1:0]         prod_hi_s;
    logic                   carry_s;
    logic [N_M-1:0]         mant_s;
    logic signed [EW-1:0]   exp_adj_s;
    logic [N_E-1:0]         res_e_s;
    logic [N_M-1:0]         res_m_s;
    logic                   ovf_s, unf_s;

    mant_mul_iter #(.N_M(N_M)) u_mant_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept_s),
        .a       ({1'b1, op1[N_M-1:0]}),
        .b       ({1'b1, op2[N_M-1:0]}),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .prod_hi (prod_hi_s)
    );

    // Next-state decode and operand acceptance
    always_comb begin
        state_n  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    state_n  = MUL;
                end else begin
                    state_n  = IDLE;
                end
            end
            MUL: begin
                if (mul_done_s && !mul_busy_s) begin
                    state_n = NORM;
                end else begin
                    state_n = MUL;
                end
            end
            NORM: state_n = DONE;
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Normalise the product, then apply zero / saturate / flush in priority order
    always_comb begin
        carry_s   = prod_hi_s[N_M+1];
        mant_s    = carry_s ? prod_hi_s[N_M:1] : prod_hi_s[N_M-1:0];
        exp_adj_s = exp_r + EW'(carry_s);
        res_e_s   = exp_adj_s[N_E-1:0];
        res_m_s   = mant_s;
        ovf_s     = 1'b0;
        unf_s     = 1'b0;
        if (zero_r) begin
            res_e_s = '0;
            res_m_s = '0;
        end else if (exp_adj_s >= E_SAT_S) begin
            res_e_s = E_MAXV;
            res_m_s = '1;
            ovf_s   = 1'b1;
        end else if (exp_adj_s <= E_ZERO_S) begin
            res_e_s = '0;
            res_m_s = '0;
            unf_s   = 1'b1;
        end else begin
            res_e_s = exp_adj_s[N_E-1:0];
            res_m_s = mant_s;
        end
    end

    // State, handshake flags, operand context and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            sign_r      <= 1'b0;
            zero_r      <= 1'b0;
            exp_r       <= '0;
        end else begin
            state_r     <= state_n;
            in_ready_r  <= (state_n == IDLE);
            out_valid_r <= (state_n == DONE);
            if (accept_s) begin
                sign_r <= op1[N_E+N_M] ^ op2[N_E+N_M];
                zero_r <= (op1[N_E+N_M-1:N_M] == '0) || (op2[N_E+N_M-1:N_M] == '0);
                // Unsigned sum minus bias wraps into the correct two's-complement value
                exp_r  <= EW'(op1[N_E+N_M-1:N_M]) + EW'(op2[N_E+N_M-1:N_M]) - EW'(E_BIAS);
            end
            if (state_r == NORM) begin
                result_r <= {sign_r, res_e_s, res_m_s};
                ovf_r    <= ovf_s;
                unf_r    <= unf_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign ovf       = ovf_r;
    assign unf       = unf_r;

endmodule

// File: tb/tb_float_mul_seq.sv
// Directed self-checking bench for float_mul_seq at N_M=23, N_E=8: arithmetic, saturation,
// zero handling, fixed latency, backpressure and mid-operation reset.
module tb_float_mul_seq;
    import float_pack::*;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready;
    logic        in_ready, out_valid, ovf, unf;
    float        op1, op2;
    logic [31:0] result;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    float_mul_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One transaction: offer, measure latency, check result, hold for 'hold' cycles, release
    task automatic run_op(input string tag, input float a, input float b,
                          input logic [31:0] exp_res, input logic exp_ovf,
                          input logic exp_unf, input int hold);
        int   cyc;
        float model;
        model = float_mul(a, b);
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        op1 = a; op2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op1 = '1; op2 = '1;
        chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd26);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_model"}, result, 32'(model));
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        chk({tag, "_unf"}, 32'(unf), 32'(exp_unf));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_result"}, result, exp_res);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'h0000_0000);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_unf", 32'(unf), 32'd0);

        // 1.5 x 2.0 = 3.0
        run_op("mul_1p5x2", '{1'b0, 8'd127, 23'h400000}, '{1'b0, 8'd128, 23'h000000},
               32'h4040_0000, 1'b0, 1'b0, 0);
        // 1.5 x 1.5 = 2.25 (carry normalisation)
        run_op("mul_1p5x1p5", '{1'b0, 8'd127, 23'h400000}, '{1'b0, 8'd127, 23'h400000},
               32'h4010_0000, 1'b0, 1'b0, 0);
        // -1.5 x 2.0 = -3.0
        run_op("mul_neg", '{1'b1, 8'd127, 23'h400000}, '{1'b0, 8'd128, 23'h000000},
               32'hC040_0000, 1'b0, 1'b0, 0);
        // Overflow saturates to largest finite value
        run_op("ovf", '{1'b0, 8'd254, 23'h000000}, '{1'b0, 8'd254, 23'h000000},
               32'h7F7F_FFFF, 1'b1, 1'b0, 0);
        // Underflow flushes to zero
        run_op("unf", '{1'b0, 8'd1, 23'h000000}, '{1'b0, 8'd1, 23'h000000},
               32'h0000_0000, 1'b0, 1'b1, 0);
        // Zero operand keeps the product sign, no flags, same latency
        run_op("zero", '{1'b1, 8'd0, 23'h000000}, '{1'b0, 8'd130, 23'h123456},
               32'h8000_0000, 1'b0, 1'b0, 0);
        // Backpressure: 5 cycles of out_ready low while result is held
        run_op("bp", '{1'b0, 8'd127, 23'h400000}, '{1'b0, 8'd128, 23'h000000},
               32'h4040_0000, 1'b0, 1'b0, 5);

        // Reset in MUL cycle 10 aborts the operation
        @(negedge clk);
        op1 = '{1'b0, 8'd127, 23'h400000};
        op2 = '{1'b0, 8'd127, 23'h400000};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        repeat (30) begin
            @(posedge clk); #1;
            chk("abort_no_stale", 32'(out_valid), 32'd0);
        end
        // 2.0 x 2.0 = 4.0 after the abort
        run_op("post_rst", '{1'b0, 8'd128, 23'h000000}, '{1'b0, 8'd128, 23'h000000},
               32'h4080_0000, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
